// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one RV32 ALU between NUM_REQ requesters and returns a tagged,
// one-deep registered response. Define ALU_ARB_LOCK_EN to add per-requester locking (req_lock).
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]  req_ctrl,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]    req_lock,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_zero,
    output logic [ID_W-1:0]       rsp_id
);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_BEQ  = 4'hA;
    localparam logic [3:0] ALU_BNE  = 4'hB;
    localparam logic [3:0] ALU_BLT  = 4'hC;
    localparam logic [3:0] ALU_BGE  = 4'hD;
    localparam logic [3:0] ALU_BLTU = 4'hE;

    // Branch codes produce a-b as result and the branch-taken condition as zero.
    function automatic logic [32:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] ctrl);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        res;
        logic               zero;
        logic               is_br;
        sa    = a;
        sb    = b;
        res   = '0;
        zero  = 1'b0;
        is_br = 1'b0;
        case (ctrl)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_SLL:  res = a << b[4:0];
            ALU_SRL:  res = a >> b[4:0];
            ALU_SRA:  res = sa >>> b[4:0];
            ALU_SLT:  res = {31'd0, sa < sb};
            ALU_SLTU: res = {31'd0, a < b};
            ALU_BEQ:  begin res = a - b; zero = (a == b);  is_br = 1'b1; end
            ALU_BNE:  begin res = a - b; zero = (a != b);  is_br = 1'b1; end
            ALU_BLT:  begin res = a - b; zero = (sa < sb); is_br = 1'b1; end
            ALU_BGE:  begin res = a - b; zero = (sa >= sb); is_br = 1'b1; end
            ALU_BLTU: begin res = a - b; zero = (a < b);   is_br = 1'b1; end
            default:  res = '0;
        endcase
        if (!is_br) begin
            zero = (res == 32'd0);
        end
        return {zero, res};
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
        if (int'(p) >= NUM_REQ - 1) begin
            return '0;
        end
        return p + ID_W'(1);
    endfunction

    // Returns {found, index} of the first valid requester at or after start, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0] start);
        logic [ID_W:0] pick;
        int            idx;
        pick = {1'b0, start};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick[ID_W] && v[idx]) begin
                pick = {1'b1, ID_W'(idx)};
            end
        end
        return pick;
    endfunction

    logic              rsp_valid_q,  rsp_valid_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic              rsp_zero_q,   rsp_zero_d;
    logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;
    logic [ID_W-1:0]   rr_ptr_q,     rr_ptr_d;
`ifdef ALU_ARB_LOCK_EN
    logic              lock_q,       lock_d;
`endif

    logic [ID_W:0]     pick;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic              can_accept;
    logic              xfer;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_ctrl;
    logic [31:0]       alu_result;
    logic              alu_zero;

    // While locked only the owner (held in rr_ptr) is eligible.
    always_comb begin
        pick = rr_pick(req_valid, rr_ptr_q);
`ifdef ALU_ARB_LOCK_EN
        if (lock_q) begin
            pick = {req_valid[rr_ptr_q], rr_ptr_q};
        end
`endif
        win_found = pick[ID_W];
        win_id    = pick[ID_W-1:0];
    end

    assign can_accept = !rsp_valid_q || rsp_ready;
    assign xfer       = win_found && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // With no winner, win_id equals rr_ptr, so the mux idles on that requester.
    assign alu_a    = req_a[32*int'(win_id) +: 32];
    assign alu_b    = req_b[32*int'(win_id) +: 32];
    assign alu_ctrl = req_ctrl[4*int'(win_id) +: 4];
    assign {alu_zero, alu_result} = alu_eval(alu_a, alu_b, alu_ctrl);

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        rr_ptr_d     = rr_ptr_q;
`ifdef ALU_ARB_LOCK_EN
        lock_d       = lock_q;
`endif
        if (xfer) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_id_d     = win_id;
            rr_ptr_d     = next_ptr(win_id);
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
`ifdef ALU_ARB_LOCK_EN
        // Locking pins rr_ptr on the owner; an idle, unlocking owner releases it.
        if (xfer && req_lock[win_id]) begin
            lock_d   = 1'b1;
            rr_ptr_d = win_id;
        end else if (xfer) begin
            lock_d   = 1'b0;
        end else if (lock_q && !req_valid[rr_ptr_q] && !req_lock[rr_ptr_q]) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_ptr(rr_ptr_q);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= '0;
            rr_ptr_q     <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
            rr_ptr_q     <= rr_ptr_d;
`ifdef ALU_ARB_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NUM_REQ=2): table of hand-computed ALU vectors plus
// arbitration, backpressure, reset and (with ALU_ARB_LOCK_EN) lock sequences against a scoreboard.
module tb_alu_arbiter;

    localparam int N = 2;

    localparam logic [3:0] C_ADD  = 4'h0;
    localparam logic [3:0] C_SUB  = 4'h1;
    localparam logic [3:0] C_AND  = 4'h2;
    localparam logic [3:0] C_OR   = 4'h3;
    localparam logic [3:0] C_XOR  = 4'h4;
    localparam logic [3:0] C_SLL  = 4'h5;
    localparam logic [3:0] C_SRL  = 4'h6;
    localparam logic [3:0] C_SRA  = 4'h7;
    localparam logic [3:0] C_SLT  = 4'h8;
    localparam logic [3:0] C_SLTU = 4'h9;
    localparam logic [3:0] C_BEQ  = 4'hA;
    localparam logic [3:0] C_BNE  = 4'hB;
    localparam logic [3:0] C_BLT  = 4'hC;
    localparam logic [3:0] C_BGE  = 4'hD;
    localparam logic [3:0] C_BLTU = 4'hE;
    localparam logic [3:0] C_BAD  = 4'hF;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N*4-1:0]    req_ctrl;
    logic [N-1:0]      req_lock;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic [0:0]        rsp_id;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
`ifdef ALU_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          id;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          rr_m;
    bit          full_m;
    bit          locked_m;
    rsp_t        sbq[$];
    logic [31:0] er_m[N];
    logic        ez_m[N];
    vec_t        tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] ctrl,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic ez, input logic lk);
        req_valid[i]         = v;
        req_ctrl[4*i +: 4]   = ctrl;
        req_a[32*i +: 32]    = a;
        req_b[32*i +: 32]    = b;
        req_lock[i]          = lk;
        er_m[i]              = er;
        ez_m[i]              = ez;
    endtask

    task automatic model_reset();
        rr_m     = 0;
        full_m   = 1'b0;
        locked_m = 1'b0;
        sbq.delete();
    endtask

    // One clock: check handshake and held response against the model, then advance both.
    task automatic step();
        logic [N-1:0] exp_ready;
        bit           found;
        int           w;
        int           idx;
        rsp_t         e;
        #1;
        found = 1'b0;
        w     = rr_m;
        if (locked_m) begin
            found = req_valid[rr_m];
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (rr_m + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    w     = idx;
                end
            end
        end
        exp_ready = '0;
        if (found && (!full_m || rsp_ready)) exp_ready[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(full_m));
        if (full_m) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: response held but nothing expected (t=%0t)", $time);
            end else begin
                e = sbq[0];
                check("rsp_result", rsp_result, e.res);
                check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                if (rsp_ready) void'(sbq.pop_front());
            end
        end
        if (exp_ready != '0) begin
            e.res  = er_m[w];
            e.zero = ez_m[w];
            e.id   = w;
            sbq.push_back(e);
            full_m = 1'b1;
            if (req_lock[w]) begin
                locked_m = 1'b1;
                rr_m     = w;
            end else begin
                locked_m = 1'b0;
                rr_m     = (w + 1) % N;
            end
        end else begin
            if (rsp_ready) full_m = 1'b0;
            if (locked_m && !req_valid[rr_m] && !req_lock[rr_m]) begin
                locked_m = 1'b0;
                rr_m     = (rr_m + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{C_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        tbl[1]  = '{C_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        tbl[2]  = '{C_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        tbl[3]  = '{C_OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{C_XOR,  32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000, 1'b1};
        tbl[5]  = '{C_SLL,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1'b0};
        tbl[6]  = '{C_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0};
        tbl[7]  = '{C_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
        tbl[8]  = '{C_SLT,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0};
        tbl[9]  = '{C_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1};
        tbl[10] = '{C_BEQ,  32'd5,         32'd5,         32'h0000_0000, 1'b1};
        tbl[11] = '{C_BNE,  32'd5,         32'd5,         32'h0000_0000, 1'b0};
        tbl[12] = '{C_BLT,  32'd1,         32'hFFFF_FFFF, 32'h0000_0002, 1'b0};
        tbl[13] = '{C_BGE,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[14] = '{C_BLTU, 32'd1,         32'hFFFF_FFFF, 32'h0000_0002, 1'b1};
        tbl[15] = '{C_BAD,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1};

        // Reset with a requester already valid: no ready, all response fields cleared.
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        req_lock  = '0;
        set_req(1, 1'b1, C_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_result", rsp_result, 32'h0);
        check("reset_rsp_zero", 32'(rsp_zero), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);
        set_req(1, 1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();

        // First transaction: ADD 5+7 from requester 0.
        set_req(0, 1'b1, C_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        step();
        set_req(0, 1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        step();

        // Table of single-requester ALU operations, alternating requester.
        for (int t = 0; t < 16; t++) begin
            set_req(t % 2, 1'b1, tbl[t].ctrl, tbl[t].a, tbl[t].b, tbl[t].res, tbl[t].zero, 1'b0);
            step();
            set_req(t % 2, 1'b0, 4'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
            step();
        end

        // Both requesters valid continuously: grants alternate.
        set_req(0, 1'b1, C_SUB, 32'd9, 32'd9, 32'h0000_0000, 1'b1, 1'b0);
        set_req(1, 1'b1, C_BLT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) step();
        set_req(0, 1'b0, C_SUB, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        set_req(1, 1'b0, C_SUB, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        step();

        // Backpressure: held response stays stable, then same-edge replace.
        set_req(0, 1'b1, C_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        step();
        set_req(0, 1'b1, C_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) step();
        rsp_ready = 1'b1;
        step();
        set_req(0, 1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        step();

        // Reset mid-operation with a pending response and requester 1 valid.
        set_req(1, 1'b1, C_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
        step();
        set_req(1, 1'b1, C_OR, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        #2;
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        check("mid_rst_rsp_result", rsp_result, 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_req_ready_edge", 32'(req_ready), 32'h0);
        rst = 1'b0;
        model_reset();
        rsp_ready = 1'b1;
        step();
        set_req(1, 1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        step();

`ifdef ALU_ARB_LOCK_EN
        // Lock: requester 0 holds the ALU for 3 ops; requester 1 waits until unlock.
        set_req(0, 1'b1, C_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
        set_req(1, 1'b1, C_SUB, 32'd5, 32'd1, 32'd4, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("lock_req1_blocked", 32'(req_ready[1]), 32'h0);
        end
        set_req(0, 1'b1, C_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        step();
        set_req(0, 1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        check("unlock_req1_granted", 32'(req_ready), 32'h2);
        step();
        set_req(1, 1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
